expr_stream_checker: RTL and testbench
======================================

Name: expr_stream_checker

Overview:
- Streaming syntax checker for arithmetic expressions, fed one 8-bit ASCII character per accepted cycle.
- Successor to the single-level expression FSM. Adds nested parentheses up to MAX_DEPTH, optional multi-digit numbers, an optional '-' operator, an input-valid qualifier, a sticky error code and a depth readout.
- Sits behind the character source in the P1 string-processing blocks. Its `out` is sampled by the testbench or next stage after each character.

Parameters:
- MAX_DEPTH, 4: maximum parenthesis nesting depth (1..15).
- MULTI_DIGIT, 1: 1 = a number is one or more digits; 0 = a number is exactly one digit.
- ALLOW_MINUS, 0: 1 = '-' is accepted as a binary operator; 0 = '-' is an illegal character.
- LEN_W, 8: width of the saturating character counter.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high; returns the block to the empty-expression state.
- in_valid  input  1  `in` is consumed on a rising clk edge only when in_valid=1.
- in  input  8  ASCII character.
- out  output  1  1 = characters consumed so far form a complete, legal expression.
- err  output  1  sticky error flag.
- err_code  output  2  0 none, 1 illegal/unexpected char, 2 depth overflow, 3 unmatched ')'.
- depth  output  $clog2(MAX_DEPTH+1)  current open-parenthesis count.
- len  output  LEN_W  characters consumed since clr, saturating at all-ones.

Behaviour:
- Grammar:
  - expr := term (op term)*
  - term := number | '(' expr ')'
  - op := '+' | '*' | '-' (the last only if ALLOW_MINUS=1)
  - digit := '0'..'9'
  - No whitespace; any other byte is illegal.
- States:
  - S_OPND: expecting an operand.
  - S_NUM: last char was a digit.
  - S_CLOSE: last char was ')'.
  - S_ERR.
- Reset (clr=1, asynchronous): state=S_OPND, depth=0, len=0, err=0, err_code=0, so out=0. clr mid-stream discards everything.
- In-valid qualifier: when in_valid=0 no register changes and `in` is ignored.
- Per accepted character, one clk edge:
  - len increments, saturating at all-ones.
  - S_OPND:
    - digit -> S_NUM.
    - '(' with depth<MAX_DEPTH -> depth+1, stay S_OPND.
    - '(' with depth==MAX_DEPTH -> S_ERR, code 2.
    - anything else -> S_ERR, code 1.
  - S_NUM:
    - digit with MULTI_DIGIT=1 -> S_NUM.
    - digit with MULTI_DIGIT=0 -> S_ERR, code 1.
    - op -> S_OPND.
    - ')' with depth>0 -> depth-1, S_CLOSE.
    - ')' with depth==0 -> S_ERR, code 3.
    - else -> S_ERR, code 1.
  - S_CLOSE:
    - op -> S_OPND.
    - ')' -> same depth rules as in S_NUM.
    - digit or '(' -> S_ERR, code 1.
    - else -> S_ERR, code 1.
  - S_ERR: absorbing; err_code holds the first error; depth frozen; len keeps counting. Only clr exits.
- Outputs:
  - out = (state==S_NUM || state==S_CLOSE) && depth==0 && !err.
  - out is combinational from registers and is valid one edge after the character is consumed.
  - err = (state==S_ERR).
  - Empty stream: out=0, err=0.
  - Incomplete stream (trailing op, or depth>0): out=0, err=0.
- Width rules: depth never exceeds MAX_DEPTH and never underflows; overflow or underflow attempts go to S_ERR without changing depth.
- Simultaneous events: clr asserted with in_valid=1 -> clr wins and the character is not counted.
- No internal initial-only reset reliance; all state is cleared by clr.

Test Plan:
- clr; feed "3+(4*(5+6))" with in_valid=1 each cycle:
  - out=1 after the final ')'.
  - depth sequence peaks at 2 and ends at 0.
  - len=11, err=0.
- MULTI_DIGIT=1 feed "12*(34)" -> out=1, len=7. With MULTI_DIGIT=0, the second char '2' -> err=1, err_code=1, out=0; later chars ignored.
- MAX_DEPTH=2 feed "(((" -> err_code=2 on the third '(', depth stays 2. Feed "1)" -> err_code=3 on ')'.
- Feed "7+" -> out=0, err=0. Then in_valid=0 for 3 cycles with random `in` -> no change. Then '8' -> out=1.
- ALLOW_MINUS=0 feed "5-2" -> err_code=1 at '-'. ALLOW_MINUS=1 -> out=1.
- Mid-stream "(1+" then assert clr asynchronously between edges -> all outputs 0 immediately. Then "9" -> out=1, len=1.

Source files
------------

// File: rtl/expr_stream_checker.sv
// expr_stream_checker
//   Streaming syntax checker for arithmetic expressions. One ASCII character
//   is consumed per clk edge while in_valid is high. The grammar is:
//     expr := term (op term)* ; term := number | '(' expr ')'
//     op   := '+' | '*' | '-' (the '-' only when ALLOW_MINUS=1)
//
// Parameters:
//   MAX_DEPTH   maximum parenthesis nesting depth (1..15)
//   MULTI_DIGIT 1: numbers are one or more digits, 0: exactly one digit
//   ALLOW_MINUS 1: '-' is a binary operator, 0: '-' is illegal
//   LEN_W       width of the saturating character counter
//
// Ports:
//   clk       clock, rising edge
//   clr       asynchronous active-high reset to the empty-expression state
//   in_valid  qualifies in; nothing changes while low
//   in        ASCII character
//   out       1 = characters so far form a complete, legal expression
//   err       sticky error flag
//   err_code  first error: 0 none, 1 illegal char, 2 depth overflow,
//             3 unmatched ')'
//   depth     current open-parenthesis count
//   len       characters consumed since clr, saturating at all-ones
module expr_stream_checker #(
  parameter int MAX_DEPTH   = 4,
  parameter int MULTI_DIGIT = 1,
  parameter int ALLOW_MINUS = 0,
  parameter int LEN_W       = 8,
  localparam int DW         = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [DW-1:0]    depth,
  output logic [LEN_W-1:0] len
);

  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);

  localparam logic [1:0] CODE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CODE_OVERFLOW = 2'd2;
  localparam logic [1:0] CODE_UNMATCH  = 2'd3;

  state_t           state, state_next;
  logic [DW-1:0]    depth_next;
  logic [1:0]       code_next;
  logic [LEN_W-1:0] len_next;

  // Character classes
  logic is_digit, is_op, is_open, is_close;

  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2A) ||
               ((ALLOW_MINUS != 0) && (in == 8'h2D));
    is_open  = (in == 8'h28);
    is_close = (in == 8'h29);
  end

  // State register; async clear returns to the empty expression
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_OPND;
      depth    <= '0;
      err_code <= 2'd0;
      len      <= '0;
    end else begin
      state    <= state_next;
      depth    <= depth_next;
      err_code <= code_next;
      len      <= len_next;
    end
  end

  // Next-state logic. Every error path leaves depth untouched so the
  // readout shows the nesting level at the point of failure.
  always_comb begin
    state_next = state;
    depth_next = depth;
    code_next  = err_code;
    len_next   = len;

    if (in_valid) begin
      if (len != '1) begin
        len_next = len + LEN_W'(1);
      end

      case (state)
        S_OPND: begin
          if (is_digit) begin
            state_next = S_NUM;
          end else if (is_open) begin
            if (depth == DEPTH_MAX) begin
              state_next = S_ERR;
              code_next  = CODE_OVERFLOW;
            end else begin
              depth_next = depth + DW'(1);
            end
          end else begin
            state_next = S_ERR;
            code_next  = CODE_ILLEGAL;
          end
        end

        S_NUM: begin
          if (is_digit) begin
            if (MULTI_DIGIT != 0) begin
              state_next = S_NUM;
            end else begin
              state_next = S_ERR;
              code_next  = CODE_ILLEGAL;
            end
          end else if (is_op) begin
            state_next = S_OPND;
          end else if (is_close) begin
            if (depth == '0) begin
              state_next = S_ERR;
              code_next  = CODE_UNMATCH;
            end else begin
              depth_next = depth - DW'(1);
              state_next = S_CLOSE;
            end
          end else begin
            state_next = S_ERR;
            code_next  = CODE_ILLEGAL;
          end
        end

        S_CLOSE: begin
          if (is_op) begin
            state_next = S_OPND;
          end else if (is_close) begin
            if (depth == '0) begin
              state_next = S_ERR;
              code_next  = CODE_UNMATCH;
            end else begin
              depth_next = depth - DW'(1);
              state_next = S_CLOSE;
            end
          end else begin
            // digit, '(' or any other byte cannot follow ')'
            state_next = S_ERR;
            code_next  = CODE_ILLEGAL;
          end
        end

        default: begin
          // S_ERR is absorbing; only len keeps counting
          state_next = S_ERR;
        end
      endcase
    end
  end

  assign err = (state == S_ERR);
  assign out = ((state == S_NUM) || (state == S_CLOSE)) && (depth == '0) && !err;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed bench for expr_stream_checker. Two instances share the stimulus:
//   a: defaults (MAX_DEPTH=4, MULTI_DIGIT=1, ALLOW_MINUS=0, LEN_W=8)
//   b: MAX_DEPTH=2, MULTI_DIGIT=0, ALLOW_MINUS=1, LEN_W=3 (len saturates at 7)
module tb_expr_stream_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;

  logic       a_out, a_err;
  logic [1:0] a_code;
  logic [2:0] a_depth;
  logic [7:0] a_len;

  logic       b_out, b_err;
  logic [1:0] b_code;
  logic [1:0] b_depth;
  logic [2:0] b_len;

  int checks = 0;
  int errors = 0;
  int peak;

  always #5 clk = ~clk;

  expr_stream_checker u_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(a_out), .err(a_err), .err_code(a_code), .depth(a_depth), .len(a_len)
  );

  expr_stream_checker #(
    .MAX_DEPTH(2), .MULTI_DIGIT(0), .ALLOW_MINUS(1), .LEN_W(3)
  ) u_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(b_out), .err(b_err), .err_code(b_code), .depth(b_depth), .len(b_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Short async clear pulse, released before the next rising edge
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    clr = 1'b0;
  endtask

  // One accepted character; returns 1 time unit after the consuming edge
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (32'(a_depth) > peak) peak = 32'(a_depth);
    end
  endtask

  initial begin
    // Reset state
    do_clr();
    #1;
    check("rst_a_out",   32'(a_out), 0);
    check("rst_a_err",   32'(a_err), 0);
    check("rst_a_code",  32'(a_code), 0);
    check("rst_a_depth", 32'(a_depth), 0);
    check("rst_a_len",   32'(a_len), 0);
    check("rst_b_len",   32'(b_len), 0);

    // Nested expression
    peak = 0;
    feed("3+(4*(5+6))");
    check("nest_a_out",   32'(a_out), 1);
    check("nest_a_peak",  32'(peak), 2);
    check("nest_a_depth", 32'(a_depth), 0);
    check("nest_a_len",   32'(a_len), 11);
    check("nest_a_err",   32'(a_err), 0);
    check("nest_b_out",   32'(b_out), 1);
    check("nest_b_len_sat", 32'(b_len), 7);

    // Multi-digit numbers
    do_clr();
    feed("12*(34)");
    check("md_a_out",  32'(a_out), 1);
    check("md_a_len",  32'(a_len), 7);
    check("md_b_err",  32'(b_err), 1);
    check("md_b_code", 32'(b_code), 1);
    check("md_b_out",  32'(b_out), 0);
    check("md_b_depth_frozen", 32'(b_depth), 0);

    // Depth overflow and unmatched close
    do_clr();
    feed("((");
    check("ovf_b_err_before", 32'(b_err), 0);
    feed("(");
    check("ovf_b_code",  32'(b_code), 2);
    check("ovf_b_depth", 32'(b_depth), 2);
    check("ovf_a_depth", 32'(a_depth), 3);
    check("ovf_a_err",   32'(a_err), 0);
    check("ovf_a_out",   32'(a_out), 0);
    do_clr();
    feed("1)");
    check("unm_a_code",  32'(a_code), 3);
    check("unm_b_code",  32'(b_code), 3);
    check("unm_a_depth", 32'(a_depth), 0);

    // Incomplete stream, idle cycles, then completion
    do_clr();
    feed("7+");
    check("inc_a_out", 32'(a_out), 0);
    check("inc_a_err", 32'(a_err), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #1;
    check("idle_a_len", 32'(a_len), 2);
    check("idle_a_out", 32'(a_out), 0);
    check("idle_a_err", 32'(a_err), 0);
    feed("8");
    check("done_a_out", 32'(a_out), 1);
    check("done_a_len", 32'(a_len), 3);

    // Minus operator
    do_clr();
    feed("5-2");
    check("minus_a_err",  32'(a_err), 1);
    check("minus_a_code", 32'(a_code), 1);
    check("minus_b_out",  32'(b_out), 1);
    check("minus_b_err",  32'(b_err), 0);

    // Illegal sequences: ')' on empty, digit after ')', errors are sticky
    do_clr();
    feed(")");
    check("empty_close_code", 32'(a_code), 1);
    do_clr();
    feed("(5)3(");
    check("close_digit_code", 32'(a_code), 1);
    check("close_digit_depth", 32'(a_depth), 0);
    check("close_digit_len", 32'(a_len), 5);

    // Asynchronous clear mid-stream
    do_clr();
    feed("(1+");
    check("pre_clr_depth", 32'(a_depth), 1);
    #2;
    clr = 1'b1;
    #1;
    check("aclr_a_depth", 32'(a_depth), 0);
    check("aclr_a_len",   32'(a_len), 0);
    check("aclr_a_out",   32'(a_out), 0);
    check("aclr_a_err",   32'(a_err), 0);
    clr = 1'b0;
    feed("9");
    check("after_clr_out", 32'(a_out), 1);
    check("after_clr_len", 32'(a_len), 1);

    // clr held across an edge with a valid character: character is dropped
    @(negedge clk);
    clr = 1'b1;
    in = 8'h35;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_wins_len", 32'(a_len), 0);
    check("clr_wins_out", 32'(a_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
